// File: rtl/ikari_vreg_pkg.sv
// Shared types and default addresses for the video register write path.
package ikari_vreg_pkg;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_BSET,
    SEL_SSET,
    SEL_MSET,
    SEL_F1SY,
    SEL_F2SY
  } reg_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } wr_state_t;

  localparam logic [15:0] BSET_ADDR_DEF = 16'hC800;
  localparam logic [15:0] SSET_ADDR_DEF = 16'hC810;
  localparam logic [15:0] MSET_ADDR_DEF = 16'hC820;
  localparam logic [15:0] F1SY_ADDR_DEF = 16'hC830;
  localparam logic [15:0] F2SY_ADDR_DEF = 16'hC840;
  localparam logic [15:0] ADDR_MASK_DEF = 16'hFFFF;

  typedef struct packed {
    logic       full;
    reg_sel_t   sel;
    logic [7:0] data;
  } slot_t;

  // Map a CPU address onto one of the video registers (SEL_NONE if unmapped).
  function automatic reg_sel_t decode_sel(
    input logic [15:0] addr,
    input logic [15:0] mask,
    input logic [15:0] bset,
    input logic [15:0] sset,
    input logic [15:0] mset,
    input logic [15:0] f1sy,
    input logic [15:0] f2sy
  );
    reg_sel_t s;
    s = SEL_NONE;
    if      ((addr & mask) == (bset & mask)) s = SEL_BSET;
    else if ((addr & mask) == (sset & mask)) s = SEL_SSET;
    else if ((addr & mask) == (mset & mask)) s = SEL_MSET;
    else if ((addr & mask) == (f1sy & mask)) s = SEL_F1SY;
    else if ((addr & mask) == (f2sy & mask)) s = SEL_F2SY;
    return s;
  endfunction

endpackage

// File: rtl/ikari_vreg_cpu_port.sv
// One CPU's write detector: edge detect, decode, armed flag, one-entry slot, wait.
module ikari_vreg_cpu_port
  import ikari_vreg_pkg::*;
#(
  parameter logic [15:0] BSET_ADDR = BSET_ADDR_DEF,
  parameter logic [15:0] SSET_ADDR = SSET_ADDR_DEF,
  parameter logic [15:0] MSET_ADDR = MSET_ADDR_DEF,
  parameter logic [15:0] F1SY_ADDR = F1SY_ADDR_DEF,
  parameter logic [15:0] F2SY_ADDR = F2SY_ADDR_DEF,
  parameter logic [15:0] ADDR_MASK = ADDR_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        mreq_n,
  input  logic        wr_n,
  input  logic        clr,
  output logic        wait_n,
  output slot_t       slot
);

  logic     wr_act;
  logic     hit;
  logic     slot_empty;
  reg_sel_t dec_sel;

  logic     wr_prev_q, wr_prev_d;
  logic     armed_q, armed_d;
  reg_sel_t armed_sel_q, armed_sel_d;
  slot_t    slot_q, slot_d;

  // Detect write rising edge, arm on a mapped hit, capture into slot when it frees.
  always_comb begin
    wr_act      = ~mreq_n & ~wr_n;
    dec_sel     = decode_sel(addr, ADDR_MASK, BSET_ADDR, SSET_ADDR,
                             MSET_ADDR, F1SY_ADDR, F2SY_ADDR);
    hit         = wr_act & ~wr_prev_q & (dec_sel != SEL_NONE);
    wr_prev_d   = wr_act;
    // A slot being strobed this cycle counts as empty so it can refill at once.
    slot_empty  = ~slot_q.full | clr;
    armed_d     = armed_q;
    armed_sel_d = armed_sel_q;
    slot_d      = slot_q;
    if (clr) slot_d.full = 1'b0;
    if (hit) begin
      armed_d     = 1'b1;
      armed_sel_d = dec_sel;
    end
    if (armed_d && slot_empty) begin
      slot_d.full = 1'b1;
      slot_d.sel  = armed_sel_d;
      slot_d.data = dout;
      armed_d     = 1'b0;
    end
    wait_n = ~(armed_q & slot_q.full & ~clr);
  end

  // Port state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      armed_sel_q <= SEL_NONE;
      slot_q      <= '0;
    end else begin
      wr_prev_q   <= wr_prev_d;
      armed_q     <= armed_d;
      armed_sel_q <= armed_sel_d;
      slot_q      <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/ikari_vreg_writer.sv
// Arbitrates video register writes from two CPUs onto VD and the latch strobes.
module ikari_vreg_writer
  import ikari_vreg_pkg::*;
#(
  parameter logic [15:0] BSET_ADDR = BSET_ADDR_DEF,
  parameter logic [15:0] SSET_ADDR = SSET_ADDR_DEF,
  parameter logic [15:0] MSET_ADDR = MSET_ADDR_DEF,
  parameter logic [15:0] F1SY_ADDR = F1SY_ADDR_DEF,
  parameter logic [15:0] F2SY_ADDR = F2SY_ADDR_DEF,
  parameter logic [15:0] ADDR_MASK = ADDR_MASK_DEF
) (
  input  logic        clk,
  input  logic        VIDEO_RSTn,
  input  logic [15:0] cpua_addr,
  input  logic [7:0]  cpua_dout,
  input  logic        cpua_mreq_n,
  input  logic        cpua_wr_n,
  output logic        cpua_wait_n,
  input  logic [15:0] cpub_addr,
  input  logic [7:0]  cpub_dout,
  input  logic        cpub_mreq_n,
  input  logic        cpub_wr_n,
  output logic        cpub_wait_n,
  output logic [7:0]  VD_out,
  output logic        BSET,
  output logic        SSET,
  output logic        MSET,
  output logic        F1SY,
  output logic        F2SY
);

  slot_t     slot_a, slot_b;
  logic      clr_a, clr_b;
  reg_sel_t  strobe_sel;

  wr_state_t state_q, state_d;
  logic      ptr_q, ptr_d;   // 0 = CPU A next on contention
  logic      gnt_q, gnt_d;   // 0 = CPU A granted
  logic [7:0] vd_q, vd_d;

  ikari_vreg_cpu_port #(
    .BSET_ADDR(BSET_ADDR), .SSET_ADDR(SSET_ADDR), .MSET_ADDR(MSET_ADDR),
    .F1SY_ADDR(F1SY_ADDR), .F2SY_ADDR(F2SY_ADDR), .ADDR_MASK(ADDR_MASK)
  ) u_port_a (
    .clk(clk), .rst_n(VIDEO_RSTn), .addr(cpua_addr), .dout(cpua_dout),
    .mreq_n(cpua_mreq_n), .wr_n(cpua_wr_n), .clr(clr_a),
    .wait_n(cpua_wait_n), .slot(slot_a)
  );

  ikari_vreg_cpu_port #(
    .BSET_ADDR(BSET_ADDR), .SSET_ADDR(SSET_ADDR), .MSET_ADDR(MSET_ADDR),
    .F1SY_ADDR(F1SY_ADDR), .F2SY_ADDR(F2SY_ADDR), .ADDR_MASK(ADDR_MASK)
  ) u_port_b (
    .clk(clk), .rst_n(VIDEO_RSTn), .addr(cpub_addr), .dout(cpub_dout),
    .mreq_n(cpub_mreq_n), .wr_n(cpub_wr_n), .clr(clr_b),
    .wait_n(cpub_wait_n), .slot(slot_b)
  );

  // Arbiter state, round-robin pointer, grant and VD data register.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vd_q    <= vd_d;
    end
  end

  // Next state: grant a full slot in IDLE, then give the latch bank a setup clock.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    vd_d    = vd_q;
    unique case (state_q)
      IDLE: begin
        if (slot_a.full || slot_b.full) begin
          gnt_d   = (slot_a.full && slot_b.full) ? ptr_q : slot_b.full;
          // Both the contended toggle and the single-grant rule reduce to this.
          ptr_d   = ~gnt_d;
          vd_d    = gnt_d ? slot_b.data : slot_a.data;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-clock strobe for the granted register, and slot release.
  always_comb begin
    clr_a      = (state_q == STROBE) && !gnt_q;
    clr_b      = (state_q == STROBE) &&  gnt_q;
    strobe_sel = SEL_NONE;
    if (state_q == STROBE) strobe_sel = gnt_q ? slot_b.sel : slot_a.sel;
    BSET   = (strobe_sel == SEL_BSET);
    SSET   = (strobe_sel == SEL_SSET);
    MSET   = (strobe_sel == SEL_MSET);
    F1SY   = (strobe_sel == SEL_F1SY);
    F2SY   = (strobe_sel == SEL_F2SY);
    VD_out = vd_q;
  end

endmodule

// File: tb/tb_ikari_vreg_writer.sv
// Directed bench for ikari_vreg_writer with hand-computed cycle expectations.
module tb_ikari_vreg_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_a = '0, addr_b = '0;
  logic [7:0]  dout_a = '0, dout_b = '0;
  logic        mreq_a = 1'b1, wr_a = 1'b1, mreq_b = 1'b1, wr_b = 1'b1;
  logic        wait_a, wait_b;
  logic [7:0]  vd;
  logic        s_bset, s_sset, s_mset, s_f1sy, s_f2sy;
  logic [4:0]  strb;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_bad = 0;

  localparam logic [4:0] ST_BSET = 5'h01;
  localparam logic [4:0] ST_SSET = 5'h02;
  localparam logic [4:0] ST_MSET = 5'h04;
  localparam logic [4:0] ST_F1SY = 5'h08;
  localparam logic [4:0] ST_F2SY = 5'h10;

  ikari_vreg_writer dut (
    .clk(clk), .VIDEO_RSTn(rst_n),
    .cpua_addr(addr_a), .cpua_dout(dout_a), .cpua_mreq_n(mreq_a),
    .cpua_wr_n(wr_a), .cpua_wait_n(wait_a),
    .cpub_addr(addr_b), .cpub_dout(dout_b), .cpub_mreq_n(mreq_b),
    .cpub_wr_n(wr_b), .cpub_wait_n(wait_b),
    .VD_out(vd), .BSET(s_bset), .SSET(s_sset), .MSET(s_mset),
    .F1SY(s_f1sy), .F2SY(s_f2sy)
  );

  assign strb = {s_f2sy, s_f1sy, s_mset, s_sset, s_bset};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count strobe cycles and any cycle with more than one strobe high.
  always @(negedge clk) begin
    if (strb != 5'h0) begin
      n_strobe = n_strobe + 1;
      if ($countones(strb) != 1) n_bad = n_bad + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Start of cycle c (just after its rising edge), for driving inputs.
  task automatic drive_at(input int c);
    do begin @(posedge clk); #1; end while (cyc < c);
  endtask

  // Middle of cycle c (falling edge), for sampling outputs.
  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wr_a_go(input logic [15:0] a, input logic [7:0] d);
    addr_a = a; dout_a = d; mreq_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic wr_b_go(input logic [15:0] a, input logic [7:0] d);
    addr_b = a; dout_b = d; mreq_b = 1'b0; wr_b = 1'b0;
  endtask

  task automatic rel_a();
    mreq_a = 1'b1; wr_a = 1'b1;
  endtask

  task automatic rel_b();
    mreq_b = 1'b1; wr_b = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rel_a(); rel_b();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int s0;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_reset", {vd, strb, wait_a, wait_b}, {8'h00, 5'h00, 2'b11});
    end

    // Single CPU A write to F1SY, held asserted for several clocks
    drive_at(cyc + 1); n = cyc; s0 = n_strobe;
    wr_a_go(16'hC830, 8'h5A);
    at_cycle(n + 1);
    check("f1sy_n1_vd", vd, 8'h00);
    check("f1sy_n1_wait", wait_a, 1'b1);
    at_cycle(n + 2);
    check("f1sy_n2_vd", vd, 8'h5A);
    check("f1sy_n2_strb", strb, 5'h00);
    at_cycle(n + 3);
    check("f1sy_n3_strb", strb, ST_F1SY);
    check("f1sy_n3_vd", vd, 8'h5A);
    at_cycle(n + 4);
    check("f1sy_n4_strb", strb, 5'h00);
    drive_at(n + 6); rel_a();
    at_cycle(n + 9);
    check("f1sy_single_hit", n_strobe - s0, 1);

    // Unmapped write: ignored, no stall
    drive_at(cyc + 1); n = cyc; s0 = n_strobe;
    wr_a_go(16'hC850, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      at_cycle(n + k);
      check("unmapped_quiet", {vd, strb, wait_a}, {8'h5A, 5'h00, 1'b1});
    end
    drive_at(n + 6); rel_a();
    at_cycle(n + 8);
    check("unmapped_no_strobe", n_strobe - s0, 0);

    // Simultaneous pair from reset pointer (A first); A re-writes while B is pending
    do_reset();
    drive_at(cyc + 1); n = cyc; s0 = n_strobe;
    wr_a_go(16'hC800, 8'h20);
    wr_b_go(16'hC840, 8'h7F);
    at_cycle(n + 1);
    check("pair_n1_wait", {wait_a, wait_b}, 2'b11);
    drive_at(n + 1); rel_a();
    drive_at(n + 2); wr_a_go(16'hC820, 8'h33);
    at_cycle(n + 3);
    check("pair_bset_strb", strb, ST_BSET);
    check("pair_bset_vd", vd, 8'h20);
    check("pair_n3_wait_a", wait_a, 1'b1);
    at_cycle(n + 4);
    check("pair_n4_strb", strb, 5'h00);
    at_cycle(n + 5);
    check("pair_n5_vd", vd, 8'h7F);
    at_cycle(n + 6);
    check("pair_f2sy_strb", strb, ST_F2SY);
    check("pair_f2sy_vd", vd, 8'h7F);
    at_cycle(n + 9);
    check("pair_mset_strb", strb, ST_MSET);
    check("pair_mset_vd", vd, 8'h33);
    drive_at(n + 10); rel_a(); rel_b();
    at_cycle(n + 12);
    check("pair_strobe_count", n_strobe - s0, 3);

    // Next simultaneous pair: pointer now at B, so B is served first
    drive_at(cyc + 1); n = cyc;
    wr_a_go(16'hC810, 8'h66);
    wr_b_go(16'hC830, 8'h77);
    at_cycle(n + 3);
    check("pair2_first_strb", strb, ST_F1SY);
    check("pair2_first_vd", vd, 8'h77);
    at_cycle(n + 6);
    check("pair2_second_strb", strb, ST_SSET);
    check("pair2_second_vd", vd, 8'h66);
    drive_at(n + 7); rel_a(); rel_b();

    // Reset during SETUP of a pending F2SY write
    drive_at(cyc + 2); n = cyc; s0 = n_strobe;
    wr_b_go(16'hC840, 8'h99);
    at_cycle(n + 2);
    check("rst_setup_vd", vd, 8'h99);
    check("rst_setup_strb", strb, 5'h00);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {vd, strb, wait_b}, {8'h00, 5'h00, 1'b1});
    rel_b();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      at_cycle(n + k);
      check("rst_after_release", {strb, wait_a, wait_b}, {5'h00, 2'b11});
    end
    check("rst_no_strobe", n_strobe - s0, 0);

    // Back-to-back B writes while B's first write waits behind A: stall then MSET
    drive_at(cyc + 1); n = cyc;
    wr_a_go(16'hC800, 8'h44);
    wr_b_go(16'hC810, 8'h11);
    drive_at(n + 1); rel_a(); rel_b();
    drive_at(n + 2); wr_b_go(16'hC820, 8'h22);
    at_cycle(n + 2);
    check("b2b_n2_wait_b", wait_b, 1'b1);
    at_cycle(n + 3);
    check("b2b_bset_strb", strb, ST_BSET);
    check("b2b_bset_vd", vd, 8'h44);
    check("b2b_n3_wait_b", wait_b, 1'b0);
    at_cycle(n + 4);
    check("b2b_n4_wait_b", wait_b, 1'b0);
    at_cycle(n + 5);
    check("b2b_n5_wait_b", wait_b, 1'b0);
    at_cycle(n + 6);
    check("b2b_sset_wait_b", wait_b, 1'b1);
    check("b2b_sset_strb", strb, ST_SSET);
    check("b2b_sset_vd", vd, 8'h11);
    at_cycle(n + 7);
    check("b2b_n7_wait_b", wait_b, 1'b1);
    at_cycle(n + 9);
    check("b2b_mset_strb", strb, ST_MSET);
    check("b2b_mset_vd", vd, 8'h22);
    drive_at(n + 10); rel_b();
    at_cycle(n + 13);

    check("strobe_onehot_violations", n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ikari_vreg_writer.md
Name: ikari_vreg_writer

Overview:
- CPU-side initiator for the video register latches (BSET, SSET, MSET, F1SY, F2SY).
- Detects memory writes from the two Z80s (CPU A, CPU B) into the video register window and arbitrates between them.
- Drives the shared VD data bus and issues exactly one single-clock strobe per write.
- Strobe timing accounts for the one-clock VD input register at the latch bank.

Parameters:
BSET_ADDR, 16'hC800, address of BSET (B1X8/B1Y8/INV)
SSET_ADDR, 16'hC810, address of SSET (side bank/palette)
MSET_ADDR, 16'hC820, address of MSET (front scroll MSBs)
F1SY_ADDR, 16'hC830, address of F1SY (front1 Y LSB)
F2SY_ADDR, 16'hC840, address of F2SY (front2 Y LSB)
ADDR_MASK, 16'hFFFF, bits compared when decoding (1 = compared)

Ports:
clk  in  1  system clock; all CPUs run on enables of this clock
VIDEO_RSTn  in  1  reset
cpua_addr  in  16  CPU A address
cpua_dout  in  8  CPU A write data
cpua_mreq_n  in  1  CPU A memory request, active low
cpua_wr_n  in  1  CPU A write, active low
cpua_wait_n  out  1  CPU A wait, low = stall
cpub_addr / cpub_dout / cpub_mreq_n / cpub_wr_n / cpub_wait_n  same as CPU A, for CPU B
VD_out  out  8  data bus to register latches
BSET, SSET, MSET, F1SY, F2SY  out  1 each  single-clock write strobes, active high

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (VIDEO_RSTn).
- Reset values:
  - VD_out = 0; all strobes = 0; wait_n = 1.
  - Slots empty; FSM in IDLE; round-robin pointer points at CPU A.
  - Reset mid-write discards all pending writes. No strobe is emitted after reset.
- Per-CPU port:
  - wr_act = ~mreq_n & ~wr_n.
  - Hit = wr_act rising edge (previous-cycle register) AND (addr & ADDR_MASK) == (REG_ADDR & ADDR_MASK) for one register.
  - A hit sets armed. Unmapped writes are ignored with no wait.
  - Capture: when armed & slot empty, load slot {sel, data} and clear armed.
  - wait_n = ~(armed & slot_full). The CPU holds addr and data while stalled.
  - If armed is set with the slot empty in the same cycle, capture happens that cycle.
- Arbiter FSM (states IDLE, SETUP, STROBE):
  - IDLE:
    - If either slot is full, grant it and load VD_out = slot data, then go to SETUP.
    - If both are full, grant the CPU the pointer selects, then toggle the pointer to the other CPU.
    - If only one is full, grant it and set the pointer to the other CPU.
  - SETUP: hold VD_out. Receiver captures it into its input register.
  - STROBE: assert the granted sel strobe for exactly one clock, clear the granted slot, return to IDLE.
- Latency: hit detected in cycle N → slot full at N+1 → VD_out valid from N+2 → strobe high in N+3.
- Throughput: one write per 3 clocks sustained.
- VD_out holds its last value while IDLE.
- Strobes are one-hot or zero. Two strobes are never high in the same cycle.
- A slot cleared in STROBE may be refilled in the same cycle (wait_n releases the same cycle).
- Simultaneous hits from both CPUs: both slots capture. Writes are strobed back-to-back in round-robin order.
- If both writes target the same register, the later-granted data is the final latched value.
- A write that stays asserted (no new falling edge) produces exactly one hit.

Decomposition:
- Package ikari_vreg_pkg holds:
  - reg_sel_t enum: SEL_NONE, SEL_BSET, SEL_SSET, SEL_MSET, SEL_F1SY, SEL_F2SY.
  - wr_state_t enum: IDLE, SETUP, STROBE.
  - Default register address constants.
  - slot_t struct: {full, sel, data}.
- Sub-module ikari_vreg_cpu_port, instantiated twice. It contains:
  - edge detect and address decode;
  - the armed flag and the one-entry slot;
  - wait_n generation.
- The top level contains the arbiter FSM, round-robin pointer, VD_out register and strobe decode.

Test Plan:
- Reset then idle → VD_out=0, all strobes 0, both wait_n=1 for 20 clocks.
- CPU A writes 8'h5A to 16'hC830 at cycle N → VD_out=8'h5A from N+2, F1SY high only in N+3, no other strobe.
- CPU A writes to 16'hC850 (unmapped) → no strobe, wait_n stays 1.
- CPU A (C800, 8'h20) and CPU B (C840, 8'h7F) hit the same cycle → BSET with VD 8'h20, then F2SY with VD 8'h7F, 3 clocks apart. Next simultaneous pair is served B first.
- CPU B writes C810 then C820 one clock after the first capture → second write sees wait_n=0 until the SSET strobe cycle. MSET follows 3 clocks after SSET with correct data.
- VIDEO_RSTn pulsed low during SETUP of a pending F2SY write → no F2SY strobe, slots empty, wait_n=1 after release.
